// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches over a req/gnt/rvalid port and
// hands pc/inst to IF/ID. Handles redirects, interrupts and WFI sleep.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        next_pc_sel,
    input  logic [31:0] branch_target,
    input  logic        intr_ex,
    input  logic        intr_end_ex,
    input  logic [31:0] mtvec,
    input  logic [31:0] mepc,
    input  logic        wfi_signal,
    input  logic [31:0] wfi_pc,
    input  logic        irq_wake,
    output logic        im_req,
    output logic [31:0] im_addr,
    input  logic        im_gnt,
    input  logic        im_rvalid,
    input  logic [31:0] im_rdata,
    output logic [31:0] pc,
    output logic [31:0] inst,
    output logic        stall_IF,
    output logic [2:0]  dbg_state_o
);

    typedef enum logic [2:0] {
        S_ISSUE = 3'd0,
        S_WAIT  = 3'd1,
        S_VALID = 3'd2,
        S_SLEEP = 3'd3,
        S_DRAIN = 3'd4
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic        drop_q, drop_d;
    logic        wake_q, wake_d;

    logic        redir;
    logic        to_sleep;
    logic [31:0] target;

    // WFI only wins when no higher-priority redirect is present.
    always_comb begin
        redir    = intr_ex | intr_end_ex | next_pc_sel | wfi_signal;
        to_sleep = wfi_signal & ~(intr_ex | intr_end_ex | next_pc_sel);
        if (intr_ex)          target = mtvec;
        else if (intr_end_ex) target = mepc;
        else if (next_pc_sel) target = branch_target;
        else                  target = wfi_pc;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_ISSUE;
            pc_q    <= RESET_PC;
            inst_q  <= 32'h0;
            drop_q  <= 1'b0;
            wake_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            drop_q  <= drop_d;
            wake_q  <= wake_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        inst_d   = inst_q;
        drop_d   = drop_q;
        wake_d   = wake_q;
        im_req   = 1'b0;
        stall_IF = 1'b1;
        case (state_q)
            S_ISSUE: begin
                im_req = 1'b1;
                if (redir) begin
                    pc_d = target;
                    // A grant this cycle accepted the old address: its response must be dropped.
                    if (im_gnt) begin
                        drop_d  = 1'b1;
                        state_d = to_sleep ? S_DRAIN : S_WAIT;
                    end else begin
                        state_d = to_sleep ? S_SLEEP : S_ISSUE;
                    end
                end else if (im_gnt) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redir) begin
                    pc_d = target;
                    if (im_rvalid) begin
                        drop_d  = 1'b0;
                        state_d = to_sleep ? S_SLEEP : S_ISSUE;
                    end else begin
                        drop_d  = 1'b1;
                        state_d = to_sleep ? S_DRAIN : S_WAIT;
                    end
                end else if (im_rvalid) begin
                    if (drop_q) begin
                        drop_d  = 1'b0;
                        state_d = S_ISSUE;
                    end else begin
                        inst_d  = im_rdata;
                        state_d = S_VALID;
                    end
                end
            end
            S_VALID: begin
                stall_IF = 1'b0;
                if (redir) begin
                    pc_d    = target;
                    state_d = to_sleep ? S_SLEEP : S_ISSUE;
                end else if (!stall) begin
                    pc_d    = pc_q + PC_STEP;
                    state_d = S_ISSUE;
                end
            end
            S_SLEEP: begin
                if (intr_ex) begin
                    pc_d    = mtvec;
                    wake_d  = 1'b0;
                    state_d = S_ISSUE;
                end else if (irq_wake || wake_q) begin
                    wake_d  = 1'b0;
                    state_d = S_ISSUE;
                end
            end
            S_DRAIN: begin
                // Wake requests seen while draining are held so SLEEP is left right away.
                if (intr_ex) begin
                    pc_d   = mtvec;
                    wake_d = 1'b1;
                end else if (irq_wake) begin
                    wake_d = 1'b1;
                end
                if (im_rvalid) begin
                    drop_d  = 1'b0;
                    state_d = S_SLEEP;
                end
            end
            default: state_d = S_ISSUE;
        endcase
    end

    assign im_addr     = {pc_q[31:2], 2'b00};
    assign pc          = pc_q;
    assign inst        = inst_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: randomized memory timing and redirects, scored
// against a model of the expected delivered pc stream.
module tb_if_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        next_pc_sel = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic        intr_ex = 1'b0;
  logic        intr_end_ex = 1'b0;
  logic [31:0] mtvec = 32'h0;
  logic [31:0] mepc = 32'h0;
  logic        wfi_signal = 1'b0;
  logic [31:0] wfi_pc = 32'h0;
  logic        irq_wake = 1'b0;
  logic        im_req;
  logic [31:0] im_addr;
  logic        im_gnt = 1'b0;
  logic        im_rvalid = 1'b0;
  logic [31:0] im_rdata = 32'h0;
  logic [31:0] pc;
  logic [31:0] inst;
  logic        stall_IF;
  logic [2:0]  dbg_state;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];
  logic [31:0] gnt_log[$];
  logic        mem_busy = 1'b0;
  logic [31:0] mem_addr = 32'h0;
  int          mem_cnt = 0;
  int          gnt_pct = 100;
  int          lat_min = 1;
  int          lat_max = 1;
  logic        gnt_now = 1'b0;
  logic        done = 1'b0;

  if_fetch_unit #(.RESET_PC(RESET_PC), .PC_STEP(32'd4)) dut (
    .clk(clk), .rst(rst), .stall(stall), .next_pc_sel(next_pc_sel),
    .branch_target(branch_target), .intr_ex(intr_ex), .intr_end_ex(intr_end_ex),
    .mtvec(mtvec), .mepc(mepc), .wfi_signal(wfi_signal), .wfi_pc(wfi_pc),
    .irq_wake(irq_wake), .im_req(im_req), .im_addr(im_addr), .im_gnt(im_gnt),
    .im_rvalid(im_rvalid), .im_rdata(im_rdata), .pc(pc), .inst(inst),
    .stall_IF(stall_IF), .dbg_state_o(dbg_state)
  );

  always #5 clk = ~clk;

  // Memory contents: an odd-multiplier hash, so every address returns a distinct word.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timeout, dut state %0d (t=%0t)", name, dbg_state, $time);
  endtask

  // One clock: clear one-shot controls, then run the memory for this cycle.
  task automatic cycle();
    @(posedge clk);
    #1;
    rst = 1'b0; stall = 1'b0; next_pc_sel = 1'b0; intr_ex = 1'b0;
    intr_end_ex = 1'b0; wfi_signal = 1'b0; irq_wake = 1'b0;
    im_rvalid = 1'b0; im_gnt = 1'b0; gnt_now = 1'b0; im_rdata = $urandom;
    if (mem_busy) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        im_rvalid = 1'b1;
        im_rdata  = mem_word(mem_addr);
        mem_busy  = 1'b0;
      end
    end
    if (im_req === 1'b1 && !mem_busy && int'($urandom_range(99, 0)) < gnt_pct) begin
      im_gnt   = 1'b1;
      gnt_now  = 1'b1;
      mem_busy = 1'b1;
      mem_addr = im_addr;
      mem_cnt  = int'($urandom_range(lat_max, lat_min));
      gnt_log.push_back(im_addr);
    end
  endtask

  task automatic wait_grant(input int budget, input string name, output logic [31:0] a);
    int n = 0;
    a = 32'hxxxx_xxxx;
    do begin
      cycle();
      n++;
    end while (!gnt_now && n < budget);
    if (gnt_now) a = gnt_log[gnt_log.size() - 1];
    else fail_now(name);
  endtask

  task automatic wait_valid_pc(input logic [31:0] a, input int budget, input string name);
    int n = 0;
    while (!(stall_IF === 1'b0 && pc === a) && n < budget) begin
      cycle();
      n++;
    end
    check(name, pc, a);
  endtask

  function automatic logic [31:0] log_at(input int i);
    if (i < gnt_log.size()) return gnt_log[i];
    return 32'hxxxx_xxxx;
  endfunction

  function automatic logic [31:0] rand_addr();
    if ($urandom_range(9, 0) == 0) return 32'hFFFF_FFFC;
    return 32'($urandom_range(1023, 0)) << 2;
  endfunction

  initial begin
    fork
      // Monitor/scoreboard: compare every delivered pc/inst, then advance the model.
      begin
        logic [31:0] p;
        while (!done) begin
          @(negedge clk);
          if (stall_IF === 1'b0) begin
            if (exp_q.size() == 0) begin
              fail_now("deliver_unexpected");
            end else begin
              check("deliver_pc", pc, exp_q[0]);
              check("deliver_inst", inst, mem_word(exp_q[0]));
              check("valid_no_req", 32'(im_req), 32'h0);
            end
          end
          if (rst) begin
            exp_q.delete(); exp_q.push_back(RESET_PC);
          end else if (intr_ex) begin
            exp_q.delete(); exp_q.push_back(mtvec);
          end else if (intr_end_ex) begin
            exp_q.delete(); exp_q.push_back(mepc);
          end else if (next_pc_sel) begin
            exp_q.delete(); exp_q.push_back(branch_target);
          end else if (wfi_signal) begin
            exp_q.delete(); exp_q.push_back(wfi_pc);
          end else if (stall_IF === 1'b0 && !stall && exp_q.size() > 0) begin
            p = exp_q.pop_front();
            exp_q.push_back(p + 32'd4);
          end
        end
      end
      // Driver: directed scenarios followed by a randomized run.
      begin
        logic [31:0] a;
        int r;
        cycle(); rst = 1'b1;
        gnt_log.delete();
        cycle();
        check("reset_pc", pc, RESET_PC);
        check("reset_inst", inst, 32'h0);
        check("reset_stall_if", 32'(stall_IF), 32'h1);
        check("reset_im_req", 32'(im_req), 32'h1);
        check("reset_im_addr", im_addr, RESET_PC);

        wait_valid_pc(32'h8, 40, "seq_reach_8");
        check("seq_addr0", log_at(0), 32'h0);
        check("seq_addr1", log_at(1), 32'h4);
        check("seq_addr2", log_at(2), 32'h8);
        for (int i = 0; i < 3; i++) begin
          stall = 1'b1;
          cycle();
          check("stall_hold_pc", pc, 32'h8);
          check("stall_hold_inst", inst, mem_word(32'h8));
          check("stall_hold_valid", 32'(stall_IF), 32'h0);
          check("stall_no_req", 32'(im_req), 32'h0);
        end
        lat_min = 3; lat_max = 3;
        wait_grant(10, "after_stall_grant", a);
        check("after_stall_addr", a, 32'hC);

        cycle();
        next_pc_sel = 1'b1; branch_target = 32'h100;
        wait_grant(10, "branch_grant", a);
        check("branch_addr", a, 32'h100);
        lat_min = 1; lat_max = 1;
        wait_valid_pc(32'h100, 20, "branch_deliver");

        intr_ex = 1'b1; next_pc_sel = 1'b1; mtvec = 32'h200; branch_target = 32'h300;
        wait_grant(10, "intr_prio_grant", a);
        check("intr_prio_addr", a, 32'h200);
        wait_valid_pc(32'h200, 20, "intr_deliver");
        intr_end_ex = 1'b1; next_pc_sel = 1'b1; wfi_signal = 1'b1;
        mepc = 32'h280; branch_target = 32'h300; wfi_pc = 32'h40;
        wait_grant(10, "mret_prio_grant", a);
        check("mret_prio_addr", a, 32'h280);
        wait_valid_pc(32'h280, 20, "mret_deliver");

        lat_min = 3; lat_max = 3;
        wait_grant(10, "wfi_pre_grant", a);
        cycle();
        wfi_signal = 1'b1; wfi_pc = 32'h40;
        for (int i = 0; i < 12; i++) begin
          cycle();
          check("sleep_no_req", 32'(im_req), 32'h0);
          check("sleep_stall_if", 32'(stall_IF), 32'h1);
        end
        check("sleep_drained", 32'(mem_busy), 32'h0);
        irq_wake = 1'b1;
        wait_grant(10, "wake_grant", a);
        check("wake_addr", a, 32'h40);
        wait_valid_pc(32'h40, 20, "wake_deliver");

        wait_grant(10, "drain_wake_pre", a);
        cycle();
        wfi_signal = 1'b1; wfi_pc = 32'h80;
        cycle();
        irq_wake = 1'b1;
        wait_grant(5, "drain_wake_grant", a);
        check("drain_wake_addr", a, 32'h80);
        lat_min = 1; lat_max = 1;
        wait_valid_pc(32'h80, 20, "drain_wake_deliver");

        wfi_signal = 1'b1; wfi_pc = 32'h60;
        for (int i = 0; i < 5; i++) begin
          cycle();
          check("valid_sleep_no_req", 32'(im_req), 32'h0);
        end
        intr_ex = 1'b1; mtvec = 32'h200;
        wait_grant(10, "sleep_intr_grant", a);
        check("sleep_intr_addr", a, 32'h200);
        wait_valid_pc(32'h200, 20, "sleep_intr_deliver");

        lat_min = 3; lat_max = 3;
        wait_grant(10, "rst_pre_grant", a);
        cycle();
        next_pc_sel = 1'b1; branch_target = 32'h300;
        cycle();
        rst = 1'b1;
        cycle();
        check("rst_wait_im_req", 32'(im_req), 32'h1);
        check("rst_wait_im_addr", im_addr, RESET_PC);
        check("rst_wait_stall_if", 32'(stall_IF), 32'h1);
        check("rst_wait_grant", log_at(gnt_log.size() - 1), RESET_PC);
        wait_valid_pc(RESET_PC, 20, "rst_first_deliver");
        check("rst_first_inst", inst, mem_word(RESET_PC));
        lat_min = 1; lat_max = 1;

        gnt_pct = 70; lat_min = 1; lat_max = 3;
        for (int i = 0; i < 1500; i++) begin
          cycle();
          stall = ($urandom_range(3, 0) == 0);
          mtvec = rand_addr(); mepc = rand_addr();
          branch_target = rand_addr(); wfi_pc = rand_addr();
          r = int'($urandom_range(199, 0));
          if (r < 4) begin
            intr_ex = 1'b1; next_pc_sel = $urandom_range(1, 0) == 1;
            intr_end_ex = $urandom_range(1, 0) == 1;
          end else if (r < 8) begin
            intr_end_ex = 1'b1; next_pc_sel = $urandom_range(1, 0) == 1;
          end else if (r < 18) begin
            next_pc_sel = 1'b1;
          end else if (r == 199) begin
            rst = 1'b1;
          end
        end
        repeat (4) cycle();
        done = 1'b1;
      end
    join_any
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch stage that produces the pc/inst pair consumed by the IF/ID pipeline register.
- Owns the PC and issues requests on the instruction-memory request/grant/response interface.
- Drives stall_IF while no instruction is available.
- Handles branch redirect, interrupt entry/return, WFI sleep, and discards stale responses after a redirect.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
PC_STEP, 4, sequential PC increment in bytes

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
stall  in  1  ID hazard stall; current pc/inst must be held
next_pc_sel  in  1  branch/jump redirect request
branch_target  in  32  redirect target when next_pc_sel=1
intr_ex  in  1  interrupt entry; redirect to mtvec
intr_end_ex  in  1  interrupt return (mret); redirect to mepc
mtvec  in  32  trap vector address
mepc  in  32  return address
wfi_signal  in  1  WFI executed; enter sleep
wfi_pc  in  32  address following the WFI instruction
irq_wake  in  1  pending interrupt; ends sleep
im_req  out  1  instruction-memory request valid
im_addr  out  32  request address (word aligned)
im_gnt  in  1  request accepted this cycle
im_rvalid  in  1  read data valid, in request order; at most one outstanding
im_rdata  in  32  instruction word
pc  out  32  PC of delivered instruction
inst  out  32  delivered instruction
stall_IF  out  1  1 = pc/inst not valid this cycle

Behaviour:
- Reset (rst=1 at posedge):
  - pc_reg=RESET_PC, inst_buf=0, state=ISSUE, drop=0.
  - Outputs in the cycle after reset: pc=RESET_PC, inst=0, stall_IF=1, im_req=1, im_addr=RESET_PC.
  - Reset mid-transaction clears drop and abandons the outstanding response; any im_rvalid in the first post-reset cycle while in ISSUE is ignored.
- Redirect priority, highest first: intr_ex (mtvec) > intr_end_ex (mepc) > next_pc_sel (branch_target) > wfi_signal (wfi_pc, then sleep). Call the winning target T.
- States:
  - ISSUE:
    - im_req=1, im_addr=pc_reg, stall_IF=1.
    - im_gnt=1 with no redirect -> WAIT.
    - Redirect with im_gnt=0 -> pc_reg=T, stay ISSUE.
    - Redirect with im_gnt=1 (old address accepted) -> pc_reg=T, drop=1, go WAIT.
  - WAIT:
    - im_req=0, stall_IF=1.
    - On im_rvalid with drop=0: inst_buf=im_rdata -> VALID.
    - On im_rvalid with drop=1: discard, drop=0 -> ISSUE.
    - Redirect while waiting: pc_reg=T, drop=1, stay WAIT.
    - Redirect in the same cycle as im_rvalid: data discarded, pc_reg=T, drop=0 -> ISSUE.
  - VALID:
    - stall_IF=0, pc=pc_reg, inst=inst_buf, im_req=0.
    - Redirect -> pc_reg=T, ISSUE. Redirect overrides stall.
    - Else stall=1 -> hold; pc and inst must not change.
    - Else pc_reg=pc_reg+PC_STEP (32-bit wrap, no overflow flag) -> ISSUE.
  - SLEEP:
    - im_req=0, stall_IF=1.
    - intr_ex -> pc_reg=mtvec, ISSUE.
    - Else irq_wake -> ISSUE at pc_reg (=wfi_pc).
- WFI entry:
  - From ISSUE or VALID, go straight to SLEEP.
  - From WAIT, set drop and go to a DRAIN sub-state: wait for im_rvalid, discard it, then SLEEP.
  - irq_wake in DRAIN is remembered, so SLEEP is left on the following cycle.
- While stall_IF=1, pc/inst show the last pc_reg/inst_buf but are don't-care to the consumer.
- Only one request may be outstanding; im_req is never 1 in WAIT, DRAIN or SLEEP.
- Sequential throughput: 1 instruction per 3 cycles with zero-wait memory (ISSUE+gnt, WAIT+rvalid, VALID).

Test Plan:
- Reset, memory gnt/rvalid next cycle returning 32'h00000013 -> im_addr 0, 4, 8 issued in order; VALID cycles show pc=0/4/8, inst=32'h13, stall_IF=0.
- stall=1 for 3 cycles in VALID at pc=8 -> pc=8 and inst held; no im_req; after release next im_addr=12.
- next_pc_sel=1, branch_target=32'h100 asserted in WAIT for pc=12 -> response for 12 discarded; next request is 32'h100; pc 12 is never delivered.
- intr_ex and next_pc_sel asserted in the same cycle, mtvec=32'h200 -> next im_addr=32'h200.
- wfi_signal with wfi_pc=32'h40 during WAIT -> one response drained; SLEEP with im_req=0 for 10 cycles; irq_wake -> im_addr=32'h40.
- rst pulsed in WAIT with drop=1, late im_rvalid in the following cycle -> ignored; im_addr=RESET_PC; first delivery is the response to the RESET_PC request.
